// File: rtl/mips_pkg.sv
// Shared MIPS-32 decode definitions: opcodes, control-word bit positions and ALUOp codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CB_REGDST   = 11;
  localparam int CB_ALUSRC   = 10;
  localparam int CB_MEMTOREG = 9;
  localparam int CB_REGWRITE = 8;
  localparam int CB_MEMREAD  = 7;
  localparam int CB_MEMWRITE = 6;
  localparam int CB_BRANCH   = 5;
  localparam int CB_BRANCHNE = 4;
  localparam int CB_ALUOP_LO = 1;
  localparam int CB_JUMP     = 0;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

endpackage

// File: rtl/register_file.sv
// 32x32 GPR file: two combinational read ports, one clocked write port, $0 hardwired to zero,
// write-first bypass, asynchronous active-low clear.
module register_file (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // Register array: async clear, writes to $0 dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports; the reset gate keeps bypassed data from leaking out while cleared.
  always_comb begin
    rdata1_o = 32'h0000_0000;
    rdata2_o = 32'h0000_0000;
    if (!rst_n_i || raddr1_i == 5'd0) begin
      rdata1_o = 32'h0000_0000;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
    if (!rst_n_i || raddr2_i == 5'd0) begin
      rdata2_o = 32'h0000_0000;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/decode_state.sv
// MIPS-32 instruction-decode stage: field split, sign extension, control word and register file.
module decode_state
  import mips_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] writeToReg,
  input  logic        writeSig,
  output logic [31:0] signExtend,
  output logic [31:0] register1,
  output logic [31:0] register2,
  output logic [11:0] controlUnitSig,
  output logic [4:0]  rd,
  output logic [4:0]  rt,
  output logic [5:0]  funcBits
);

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  waddr_s;
  logic [11:0] ctrl_s;

  assign opcode_s   = instruction[31:26];
  assign rs_s       = instruction[25:21];
  assign rt         = instruction[20:16];
  assign rd         = instruction[15:11];
  assign funcBits   = instruction[5:0];
  assign signExtend = {{16{instruction[15]}}, instruction[15:0]};
  // R-type results land in rd; every other writing opcode targets rt.
  assign waddr_s    = (opcode_s == OP_RTYPE) ? rd : rt;

  register_file u_regfile (
    .clk_i    (Clk),
    .rst_n_i  (Reset_n),
    .raddr1_i (rs_s),
    .raddr2_i (rt),
    .waddr_i  (waddr_s),
    .wdata_i  (writeToReg),
    .we_i     (writeSig),
    .rdata1_o (register1),
    .rdata2_o (register2)
  );

  // Opcode to control word.
  always_comb begin
    ctrl_s = 12'h000;
    case (opcode_s)
      OP_RTYPE: begin
        ctrl_s[CB_REGDST]                = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_RTYPE;
      end
      OP_LW: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_MEMTOREG]              = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_MEMREAD]               = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_ADD;
      end
      OP_SW: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_MEMWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_s[CB_BRANCH]                = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_s[CB_BRANCHNE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_AND;
      end
      OP_ORI: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_OR;
      end
      OP_SLTI: begin
        ctrl_s[CB_ALUSRC]                = 1'b1;
        ctrl_s[CB_REGWRITE]              = 1'b1;
        ctrl_s[CB_ALUOP_LO +: 3]         = ALU_SLT;
      end
      OP_J: begin
        ctrl_s[CB_JUMP]                  = 1'b1;
      end
      default: begin
        ctrl_s = 12'h000;
      end
    endcase
  end

  assign controlUnitSig = ctrl_s;

endmodule

// File: tb/tb_decode_state.sv
// Directed self-checking bench for decode_state with hand-computed expectations.
module tb_decode_state;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] instruction;
  logic [31:0] writeToReg;
  logic        writeSig;
  logic [31:0] signExtend;
  logic [31:0] register1;
  logic [31:0] register2;
  logic [11:0] controlUnitSig;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [5:0]  funcBits;

  int n_checks;
  int n_errors;

  decode_state dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .instruction    (instruction),
    .writeToReg     (writeToReg),
    .writeSig       (writeSig),
    .signExtend     (signExtend),
    .register1      (register1),
    .register2      (register2),
    .controlUnitSig (controlUnitSig),
    .rd             (rd),
    .rt             (rt),
    .funcBits       (funcBits)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [31:0] op_instr [8];
  logic [11:0] op_ctrl  [8];

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    Reset_n     = 1'b0;
    instruction = 32'h0357_002C;
    writeToReg  = 32'h0000_0000;
    writeSig    = 1'b0;

    // Test 1: reset state and R-type decode
    #12;
    check_eq("rst_reg1", register1, 32'h0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_eq("t1_reg1", register1, 32'h0);
    check_eq("t1_reg2", register2, 32'h0);
    check_eq("t1_rt", {27'd0, rt}, 32'd23);
    check_eq("t1_rd", {27'd0, rd}, 32'd0);
    check_eq("t1_func", {26'd0, funcBits}, 32'h2C);
    check_eq("t1_sext", signExtend, 32'h0000_002C);
    check_eq("t1_ctrl", {20'd0, controlUnitSig}, 32'h904);

    // Test 2: field extraction, no writes
    instruction = 32'h03D5_002F; #1;
    check_eq("t2a_rt", {27'd0, rt}, 32'd21);
    check_eq("t2a_func", {26'd0, funcBits}, 32'h2F);
    check_eq("t2a_reg1", register1, 32'h0);
    check_eq("t2a_reg2", register2, 32'h0);
    @(posedge Clk); #1;
    instruction = 32'h01D0_0023; #1;
    check_eq("t2b_rt", {27'd0, rt}, 32'd16);
    check_eq("t2b_func", {26'd0, funcBits}, 32'h23);
    check_eq("t2b_reg1", register1, 32'h0);
    check_eq("t2b_reg2", register2, 32'h0);

    // Test 3: R-type write to $8 with rs=8 shows bypass before the edge
    instruction = 32'h0100_4020;
    writeToReg  = 32'hDEAD_BEEF;
    writeSig    = 1'b1; #1;
    check_eq("t3_bypass", register1, 32'hDEAD_BEEF);
    check_eq("t3_nobyp_rt0", register2, 32'h0);
    @(posedge Clk); #1;
    writeSig    = 1'b0;
    writeToReg  = 32'h0;
    instruction = 32'h0100_0000; #1;
    check_eq("t3_stored", register1, 32'hDEAD_BEEF);

    // I-type write goes to rt ($9), not rd
    instruction = 32'h2009_0005;
    writeToReg  = 32'h0000_0055;
    writeSig    = 1'b1;
    @(posedge Clk); #1;
    writeSig    = 1'b0;
    instruction = 32'h0120_0000; #1;
    check_eq("t3_itype_rt", register1, 32'h0000_0055);

    // Test 4: writes to $0 are discarded
    instruction = 32'h0000_0020;
    writeToReg  = 32'h0000_1234;
    writeSig    = 1'b1; #1;
    check_eq("t4_zero_byp", register1, 32'h0);
    @(posedge Clk); #1;
    writeSig = 1'b0; #1;
    check_eq("t4_zero_r1", register1, 32'h0);
    check_eq("t4_zero_r2", register2, 32'h0);

    // Test 5: lw decode, negative immediate, unknown opcode
    instruction = 32'h8C08_FFFC; #1;
    check_eq("t5_ctrl", {20'd0, controlUnitSig}, 32'h780);
    check_eq("t5_sext", signExtend, 32'hFFFF_FFFC);
    check_eq("t5_rt", {27'd0, rt}, 32'd8);
    check_eq("t5_reg2", register2, 32'hDEAD_BEEF);
    instruction = 32'hFC00_0000; #1;
    check_eq("t5_unknown", {20'd0, controlUnitSig}, 32'h000);

    op_instr[0] = 32'hAC00_0000; op_ctrl[0] = 12'h440;
    op_instr[1] = 32'h1000_0000; op_ctrl[1] = 12'h022;
    op_instr[2] = 32'h1400_0000; op_ctrl[2] = 12'h012;
    op_instr[3] = 32'h2000_0000; op_ctrl[3] = 12'h500;
    op_instr[4] = 32'h3000_0000; op_ctrl[4] = 12'h506;
    op_instr[5] = 32'h3400_0000; op_ctrl[5] = 12'h508;
    op_instr[6] = 32'h2800_0000; op_ctrl[6] = 12'h50A;
    op_instr[7] = 32'h0800_0000; op_ctrl[7] = 12'h001;
    for (int i = 0; i < 8; i++) begin
      instruction = op_instr[i]; #1;
      check_eq($sformatf("ctrl_op%02h", op_instr[i][31:26]),
               {20'd0, controlUnitSig}, {20'd0, op_ctrl[i]});
    end

    // Test 6: asynchronous reset mid-cycle clears without a clock edge
    instruction = 32'h0100_0000;
    @(posedge Clk); #1;
    check_eq("t6_before", register1, 32'hDEAD_BEEF);
    #2;
    Reset_n = 1'b0; #1;
    check_eq("t6_async_r1", register1, 32'h0);
    check_eq("t6_decode_held", {26'd0, funcBits}, 32'h00);
    Reset_n = 1'b1; #1;
    check_eq("t6_cleared", register1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
